// File: rtl/mdu_seq32.sv
// Sequential radix-2 MIPS32 multiply/divide unit owning HI/LO.
// Define MDU_DIV_EN to build the DIV/DIVU datapath; otherwise divide starts are ignored.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);
  logic c;

  always_comb begin
    c = ci;
    s = 32'h0;
    for (int i = 0; i < 32; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

module mdu_seq32 #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] upper_q, upper_d;
  logic [31:0] lower_q, lower_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        neg_res_q, neg_res_d;
  logic        done_q, done_d;
`ifdef MDU_DIV_EN
  logic [31:0] ndiv_q, ndiv_d;
  logic        is_div_q, is_div_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic [31:0] rem_sh, q_fix, r_fix;
  logic        ge;
`endif

  logic        a_neg, b_neg, accept;
  logic [31:0] a_mag, b_mag;
  logic [31:0] add_a, add_b, sum;
  logic        co;
  logic [63:0] prod, prod_neg;

  adder32 u_add (
    .a  (add_a),
    .b  (add_b),
    .ci (1'b0),
    .s  (sum),
    .co (co)
  );

  assign a_neg    = op[0] & a[31];
  assign b_neg    = op[0] & b[31];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign prod     = {upper_q, lower_q};
  assign prod_neg = -prod;

`ifdef MDU_DIV_EN
  assign accept = (state_q == IDLE) && start;
  assign rem_sh = {upper_q[30:0], lower_q[31]};
  // Shifted-out rem bit or adder carry means rem >= divisor.
  assign ge     = upper_q[31] | co | dz_q;
  assign q_fix  = neg_res_q ? -lower_q : lower_q;
  assign r_fix  = neg_rem_q ? -upper_q : upper_q;
`else
  assign accept = (state_q == IDLE) && start && !op[1];
`endif

  always_comb begin
    add_a = upper_q;
    add_b = lower_q[0] ? mcand_q : 32'h0;
`ifdef MDU_DIV_EN
    if (is_div_q) begin
      add_a = rem_sh;
      add_b = ndiv_q;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    upper_d   = upper_q;
    lower_d   = lower_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    done_d    = 1'b0;
`ifdef MDU_DIV_EN
    ndiv_d    = ndiv_q;
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (accept) begin
          state_d   = RUN;
          cnt_d     = 5'd0;
          mcand_d   = a_mag;
          upper_d   = 32'h0;
          lower_d   = b_mag;
          neg_res_d = a_neg ^ b_neg;
`ifdef MDU_DIV_EN
          is_div_d  = op[1];
          neg_rem_d = a_neg;
          dz_d      = (b == 32'h0);
          ndiv_d    = -b_mag;
          if (op[1]) lower_d = a_mag;
`endif
        end
      end
      RUN: begin
        cnt_d   = cnt_q + 5'd1;
        upper_d = {co, sum[31:1]};
        lower_d = {sum[0], lower_q[31:1]};
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          upper_d = ge ? sum : rem_sh;
          lower_d = {lower_q[30:0], ge};
        end
`endif
        if (cnt_q == 5'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        hi_d    = neg_res_q ? prod_neg[63:32] : prod[63:32];
        lo_d    = neg_res_q ? prod_neg[31:0] : prod[31:0];
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          hi_d = r_fix;
          lo_d = dz_q ? 32'hFFFF_FFFF : q_fix;
        end
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      mcand_q   <= 32'h0;
      upper_q   <= 32'h0;
      lower_q   <= 32'h0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
      neg_res_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef MDU_DIV_EN
      ndiv_q    <= 32'h0;
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      upper_q   <= upper_d;
      lower_q   <= lower_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      done_q    <= done_d;
`ifdef MDU_DIV_EN
      ndiv_q    <= ndiv_d;
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_seq32.sv
// Directed self-checking bench for mdu_seq32.
// Divide expectations follow MDU_DIV_EN.
module tb_mdu_seq32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_seq32 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int poke_at,
                        output int nbusy, output int ndone);
    nbusy = 0;
    ndone = 0;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = (i == poke_at);
      if (busy) nbusy++;
      if (done) begin
        ndone = i;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (hi !== 32'h0) begin errs++; $display("FAIL rst_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin errs++; $display("FAIL rst_lo got=%h exp=0", lo); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_multu;
    int nb, nd;
    @(negedge clk);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, nb, nd);
    checks++; if (nb !== 33) begin errs++; $display("FAIL multu_busy got=%0d exp=33", nb); end
    checks++; if (nd !== 34) begin errs++; $display("FAIL multu_done got=%0d exp=34", nd); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errs++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errs++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
  endtask

  task automatic test_mult_b2b;
    int nb, nd;
    @(negedge clk);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, nb, nd);
    checks++; if (nd !== 34) begin errs++; $display("FAIL mult_done got=%0d exp=34", nd); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errs++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errs++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo); end
    run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 0, nb, nd);
    checks++; if (nd !== 34) begin errs++; $display("FAIL b2b_done got=%0d exp=34", nd); end
    checks++; if (hi !== 32'h1) begin errs++; $display("FAIL b2b_hi got=%h exp=1", hi); end
    checks++; if (lo !== 32'h0) begin errs++; $display("FAIL b2b_lo got=%h exp=0", lo); end
  endtask

  task automatic test_div;
    int nb, nd;
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = hi;
    l0 = lo;
`ifdef MDU_DIV_EN
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, nb, nd);
    checks++; if (nd !== 34) begin errs++; $display("FAIL div_done got=%0d exp=34", nd); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errs++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errs++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    @(negedge clk);
    run_op(2'b10, 32'd100, 32'd7, 0, nb, nd);
    checks++; if (lo !== 32'd14) begin errs++; $display("FAIL divu_lo got=%h exp=e", lo); end
    checks++; if (hi !== 32'd2) begin errs++; $display("FAIL divu_hi got=%h exp=2", hi); end
`else
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, nb, nd);
    checks++; if (nb !== 0) begin errs++; $display("FAIL nodiv_busy got=%0d exp=0", nb); end
    checks++; if (nd !== 0) begin errs++; $display("FAIL nodiv_done got=%0d exp=0", nd); end
    run_op(2'b10, 32'd100, 32'd7, 0, nb, nd);
    checks++; if (nb !== 0) begin errs++; $display("FAIL nodivu_busy got=%0d exp=0", nb); end
    checks++; if (nd !== 0) begin errs++; $display("FAIL nodivu_done got=%0d exp=0", nd); end
    checks++; if (hi !== h0) begin errs++; $display("FAIL nodiv_hi got=%h exp=%h", hi, h0); end
    checks++; if (lo !== l0) begin errs++; $display("FAIL nodiv_lo got=%h exp=%h", lo, l0); end
`endif
  endtask

  task automatic test_div_edge;
    int nb, nd;
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = hi;
    l0 = lo;
`ifdef MDU_DIV_EN
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, nb, nd);
    checks++; if (lo !== 32'h8000_0000) begin errs++; $display("FAIL ovf_lo got=%h exp=80000000", lo); end
    checks++; if (hi !== 32'h0) begin errs++; $display("FAIL ovf_hi got=%h exp=0", hi); end
    @(negedge clk);
    run_op(2'b10, 32'd5, 32'd0, 0, nb, nd);
    checks++; if (nd !== 34) begin errs++; $display("FAIL dz_done got=%0d exp=34", nd); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errs++; $display("FAIL dz_lo got=%h exp=ffffffff", lo); end
    checks++; if (hi !== 32'd5) begin errs++; $display("FAIL dz_hi got=%h exp=5", hi); end
    @(negedge clk);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd0, 0, nb, nd);
    checks++; if (hi !== 32'hFFFF_FFF9) begin errs++; $display("FAIL dzs_hi got=%h exp=fffffff9", hi); end
`else
    run_op(2'b10, 32'd5, 32'd0, 0, nb, nd);
    checks++; if (nd !== 0) begin errs++; $display("FAIL nodz_done got=%0d exp=0", nd); end
    checks++; if (lo !== l0) begin errs++; $display("FAIL nodz_lo got=%h exp=%h", lo, l0); end
    checks++; if (hi !== h0) begin errs++; $display("FAIL nodz_hi got=%h exp=%h", hi, h0); end
`endif
  endtask

  task automatic test_mtlo;
    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    checks++; if (lo !== 32'h1234) begin errs++; $display("FAIL mtlo got=%h exp=1234", lo); end
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    checks++; if (hi !== 32'hA5A5_5A5A) begin errs++; $display("FAIL mtboth_hi got=%h exp=a5a55a5a", hi); end
    checks++; if (lo !== 32'hA5A5_5A5A) begin errs++; $display("FAIL mtboth_lo got=%h exp=a5a55a5a", lo); end
  endtask

  task automatic test_mthi_busy;
    int nd;
    nd = 0;
    @(negedge clk);
    start = 1'b1;
    op = 2'b00;
    a = 32'd6;
    b = 32'd7;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    hi_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    checks++; if (hi !== 32'hA5A5_5A5A) begin errs++; $display("FAIL mthi_busy got=%h exp=a5a55a5a", hi); end
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        nd = 1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (nd !== 1) begin errs++; $display("FAIL mthi_timeout got=%0d exp=1", nd); end
    checks++; if (hi !== 32'h0) begin errs++; $display("FAIL mthi_res_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd42) begin errs++; $display("FAIL mthi_res_lo got=%h exp=2a", lo); end
  endtask

  task automatic test_start_busy;
    int nb, nd, extra;
    extra = 0;
    @(negedge clk);
    run_op(2'b00, 32'd3, 32'd5, 10, nb, nd);
    checks++; if (nd !== 34) begin errs++; $display("FAIL sbusy_done got=%0d exp=34", nd); end
    checks++; if (lo !== 32'd15) begin errs++; $display("FAIL sbusy_lo got=%h exp=f", lo); end
    repeat (3) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++; if (extra !== 0) begin errs++; $display("FAIL sbusy_extra got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid;
    int nb, nd;
    @(negedge clk);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h5555_AAAA;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    start = 1'b1;
    op = 2'b00;
    a = 32'd9;
    b = 32'd9;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL rmid_run got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL rmid_done got=%b exp=0", done); end
    checks++; if (hi !== 32'h0) begin errs++; $display("FAIL rmid_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin errs++; $display("FAIL rmid_lo got=%h exp=0", lo); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(2'b00, 32'd6, 32'd7, 0, nb, nd);
    checks++; if (nd !== 34) begin errs++; $display("FAIL rpost_done got=%0d exp=34", nd); end
    checks++; if (lo !== 32'd42) begin errs++; $display("FAIL rpost_lo got=%h exp=2a", lo); end
    checks++; if (hi !== 32'h0) begin errs++; $display("FAIL rpost_hi got=%h exp=0", hi); end
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult_b2b;
    test_div;
    test_div_edge;
    test_mtlo;
    test_mthi_busy;
    test_start_busy;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
